// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the instruction and data requesters.
// An owner FIFO routes each in-order response back to the requester that issued it.
module mem_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     inst_req,
    input  logic [70:0]              inst_cmd,
    output logic                     inst_addr_ok,
    output logic                     inst_data_ok,
    output logic [31:0]              inst_rdata,
    input  logic                     data_req,
    input  logic [70:0]              data_cmd,
    output logic                     data_addr_ok,
    output logic                     data_data_ok,
    output logic [31:0]              data_rdata,
    output logic                     mem_req,
    output logic [70:0]              mem_cmd,
    input  logic                     mem_addr_ok,
    input  logic                     mem_data_ok,
    input  logic [31:0]              mem_rdata,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err_spurious
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C  = SW'(STARVE_LIMIT);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic          OWN_I    = 1'b0;
    localparam logic          OWN_D    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD_I = 2'd1,
        ST_HOLD_D = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [DEPTH-1:0] owner_q;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            err_q, err_d;

    logic full_s;
    logic pick_data_s;
    logic pick_inst_s;
    logic req_s;
    logic gnt_data_s;
    logic hs_s;
    logic pop_s;
    logic head_own_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PTR_LAST) begin
            next_ptr = {PW{1'b0}};
        end else begin
            next_ptr = p + PW'(1);
        end
    endfunction

    // Arbitration: data normally wins, inst gets one turn after STARVE_LIMIT data grants.
    always_comb begin
        full_s      = (count_q == DEPTH_C);
        pick_data_s = data_req & ((starve_q < LIMIT_C) | ~inst_req);
        pick_inst_s = ~pick_data_s & inst_req;
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: park on the winner until the memory accepts its address phase.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!full_s && (pick_data_s || pick_inst_s) && !mem_addr_ok) begin
                    state_d = pick_data_s ? ST_HOLD_D : ST_HOLD_I;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD_I: begin
                if (mem_addr_ok) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD_I;
                end
            end
            ST_HOLD_D: begin
                if (mem_addr_ok) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD_D;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: request/grant, plus response routing from the FIFO head.
    always_comb begin
        req_s      = 1'b0;
        gnt_data_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!full_s) begin
                    req_s      = pick_data_s | pick_inst_s;
                    gnt_data_s = pick_data_s;
                end else begin
                    req_s      = 1'b0;
                    gnt_data_s = 1'b0;
                end
            end
            ST_HOLD_I: begin
                req_s      = 1'b1;
                gnt_data_s = 1'b0;
            end
            ST_HOLD_D: begin
                req_s      = 1'b1;
                gnt_data_s = 1'b1;
            end
            default: begin
                req_s      = 1'b0;
                gnt_data_s = 1'b0;
            end
        endcase

        // Gating with resetn keeps every output quiet while reset is held.
        mem_req      = resetn & req_s;
        mem_cmd      = mem_req ? (gnt_data_s ? data_cmd : inst_cmd) : 71'd0;
        hs_s         = mem_req & mem_addr_ok;
        inst_addr_ok = hs_s & ~gnt_data_s;
        data_addr_ok = hs_s & gnt_data_s;

        pop_s        = resetn & mem_data_ok & (count_q != {CW{1'b0}});
        head_own_s   = owner_q[rd_ptr_q];
        inst_data_ok = pop_s & (head_own_s == OWN_I);
        data_data_ok = pop_s & (head_own_s == OWN_D);
        inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
        data_rdata   = data_data_ok ? mem_rdata : 32'd0;

        outstanding  = count_q;
        err_spurious = err_q;
    end

    // FIFO bookkeeping, starvation counter and spurious-response flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        err_d    = err_q;

        if (hs_s) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({hs_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (hs_s && !gnt_data_s) begin
            starve_d = {SW{1'b0}};
        end else if (hs_s && inst_req) begin
            starve_d = (starve_q == LIMIT_C) ? LIMIT_C : starve_q + SW'(1);
        end else if (hs_s) begin
            starve_d = {SW{1'b0}};
        end else begin
            starve_d = starve_q;
        end

        if (mem_data_ok && (count_q == {CW{1'b0}})) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Bookkeeping registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q  <= {DEPTH{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            starve_q <= {SW{1'b0}};
            err_q    <= 1'b0;
        end else begin
            if (hs_s) begin
                owner_q[wr_ptr_q] <= gnt_data_s ? OWN_D : OWN_I;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a queue-based
// reference model of the arbitration and in-order response routing.
module tb_mem_port_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, data_req;
    logic [70:0] inst_cmd, data_cmd;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req;
    logic [70:0] mem_cmd;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [1:0]  outstanding;
    logic        err_spurious;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_cmd(inst_cmd), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_cmd(data_cmd), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_cmd(mem_cmd), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .outstanding(outstanding), .err_spurious(err_spurious)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: who is parked on the port (0 none, 1 inst, 2 data),
    // consecutive-data-grant count, owner queue and sticky error.
    int hold_m   = 0;
    int starve_m = 0;
    int q_m[$];
    bit err_m    = 1'b0;
    int win_m    = 0;
    bit pop_m    = 1'b0;
    int own_m    = 0;
    bit inst_acc = 1'b0;
    bit data_acc = 1'b0;
    bit [9:0] gseq;

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [70:0] rnd_cmd();
        return {7'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    task automatic model_reset();
        hold_m   = 0;
        starve_m = 0;
        q_m.delete();
        err_m    = 1'b0;
    endtask

    // Compute expected outputs from the current inputs and compare.
    task automatic sample();
        logic [70:0] ecmd;
        bit full;
        #1;
        full  = (q_m.size() >= DEPTH);
        win_m = hold_m;
        if (win_m == 0 && !full) begin
            if (data_req && (starve_m < LIMIT || !inst_req)) win_m = 2;
            else if (inst_req) win_m = 1;
        end
        ecmd  = (win_m == 2) ? data_cmd : ((win_m == 1) ? inst_cmd : 71'd0);
        pop_m = mem_data_ok && (q_m.size() > 0);
        own_m = pop_m ? q_m[0] : 0;
        chk("mem_req", 71'(mem_req), 71'(win_m != 0));
        chk("mem_cmd", mem_cmd, ecmd);
        chk("inst_addr_ok", 71'(inst_addr_ok), 71'(win_m == 1 && mem_addr_ok));
        chk("data_addr_ok", 71'(data_addr_ok), 71'(win_m == 2 && mem_addr_ok));
        chk("inst_data_ok", 71'(inst_data_ok), 71'(own_m == 1));
        chk("data_data_ok", 71'(data_data_ok), 71'(own_m == 2));
        chk("inst_rdata", 71'(inst_rdata), (own_m == 1) ? 71'(mem_rdata) : 71'd0);
        chk("data_rdata", 71'(data_rdata), (own_m == 2) ? 71'(mem_rdata) : 71'd0);
        chk("outstanding", 71'(outstanding), 71'(q_m.size()));
        chk("err_spurious", 71'(err_spurious), 71'(err_m));
        inst_acc = (win_m == 1) && mem_addr_ok;
        data_acc = (win_m == 2) && mem_addr_ok;
    endtask

    // Advance the model across the clock edge, then return to the falling edge.
    task automatic advance();
        @(posedge clk);
        if (mem_data_ok && q_m.size() == 0) err_m = 1'b1;
        if (pop_m) void'(q_m.pop_front());
        if (win_m != 0 && mem_addr_ok) begin
            q_m.push_back(win_m);
            if (win_m == 1) starve_m = 0;
            else if (inst_req) starve_m = (starve_m + 1 > LIMIT) ? LIMIT : starve_m + 1;
            else starve_m = 0;
        end
        hold_m = (win_m != 0 && !mem_addr_ok) ? win_m : 0;
        @(negedge clk);
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic drain();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        for (int i = 0; i < 20 && q_m.size() > 0; i++) begin
            mem_data_ok = 1'b1;
            mem_rdata   = $urandom;
            cyc();
        end
        mem_data_ok = 1'b0;
        sample();
        chk("drain_outstanding", 71'(outstanding), 71'd0);
        advance();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"}, 71'(mem_req), 71'd0);
        chk({tag, "_mem_cmd"}, mem_cmd, 71'd0);
        chk({tag, "_addr_ok"}, 71'({inst_addr_ok, data_addr_ok}), 71'd0);
        chk({tag, "_data_ok"}, 71'({inst_data_ok, data_data_ok}), 71'd0);
        chk({tag, "_rdata"}, 71'({inst_rdata, data_rdata}), 71'd0);
        chk({tag, "_outstanding"}, 71'(outstanding), 71'd0);
        chk({tag, "_err"}, 71'(err_spurious), 71'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn      = 1'b0;
        inst_req    = 1'b1;
        data_req    = 1'b1;
        inst_cmd    = rnd_cmd();
        data_cmd    = rnd_cmd();
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h12345678;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        resetn = 1'b1;
        model_reset();

        // Single inst read, response one cycle later.
        inst_req = 1'b1; inst_cmd = {1'b0, 2'd2, 4'hF, 32'h1C80_0000, 32'd0};
        mem_addr_ok = 1'b1;
        sample();
        chk("t2_addr_ok", 71'(inst_addr_ok), 71'd1);
        advance();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1C80_0000;
        sample();
        chk("t2_data_ok", 71'(inst_data_ok), 71'd1);
        chk("t2_rdata", 71'(inst_rdata), 71'h1C80_0000);
        advance();
        mem_data_ok = 1'b0;

        // Both requesting every cycle: D,D,D,D,I,D,D,D,D,I.
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            inst_cmd    = rnd_cmd();
            data_cmd    = rnd_cmd();
            mem_data_ok = (q_m.size() > 0);
            mem_rdata   = $urandom;
            sample();
            gseq[i] = data_addr_ok;
            chk("t3_one_grant", 71'(inst_addr_ok ^ data_addr_ok), 71'd1);
            advance();
        end
        chk("t3_grant_seq", 71'(gseq), 71'b0111101111);
        drain();

        // Data parked while memory stalls; inst rises but must wait.
        data_req = 1'b1; data_cmd = {1'b1, 2'd2, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF};
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t4_hold_cmd", mem_cmd, {1'b1, 2'd2, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF});
            chk("t4_no_ok", 71'({inst_addr_ok, data_addr_ok}), 71'd0);
            advance();
            inst_req = 1'b1; inst_cmd = 71'h5_5555_5555_5555_5555;
        end
        mem_addr_ok = 1'b1;
        sample();
        chk("t4_data_ok", 71'({inst_addr_ok, data_addr_ok}), 71'b01);
        advance();
        data_req = 1'b0;
        sample();
        chk("t4_inst_next", 71'(inst_addr_ok), 71'd1);
        advance();
        drain();

        // Owner FIFO full blocks new requests; pop frees a slot on the next cycle.
        inst_req = 1'b1; mem_addr_ok = 1'b1;
        cyc();
        inst_cmd = rnd_cmd();
        cyc();
        inst_cmd = rnd_cmd();
        sample();
        chk("t5_full_req", 71'(mem_req), 71'd0);
        chk("t5_full_cnt", 71'(outstanding), 71'd2);
        advance();
        mem_data_ok = 1'b1; mem_rdata = $urandom;
        sample();
        chk("t5_pop_req", 71'(mem_req), 71'd0);
        advance();
        mem_data_ok = 1'b0;
        sample();
        chk("t5_reissue", 71'(mem_req), 71'd1);
        advance();
        drain();

        // In-order return across owners.
        inst_req = 1'b1; data_req = 1'b0; mem_addr_ok = 1'b1;
        cyc();
        inst_req = 1'b0; data_req = 1'b1; data_cmd = rnd_cmd();
        cyc();
        data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_AAAA;
        sample();
        chk("t6_i_ok", 71'({inst_data_ok, data_data_ok}), 71'b10);
        chk("t6_i_rdata", 71'(inst_rdata), 71'h0000_AAAA);
        advance();
        mem_rdata = 32'h0000_BBBB;
        sample();
        chk("t6_d_ok", 71'({inst_data_ok, data_data_ok}), 71'b01);
        chk("t6_d_rdata", 71'(data_rdata), 71'h0000_BBBB);
        chk("t6_i_rdata0", 71'(inst_rdata), 71'd0);
        advance();
        mem_data_ok = 1'b0;

        // Reset while parked in HOLD_D with traffic outstanding, then a stray response.
        data_req = 1'b1; mem_addr_ok = 1'b1;
        cyc();
        data_cmd = rnd_cmd(); mem_addr_ok = 1'b0;
        cyc();
        inst_req = 1'b1;
        cyc();
        resetn = 1'b0; mem_data_ok = 1'b1; mem_addr_ok = 1'b1;
        #1;
        chk_all_zero("t7_rst");
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        resetn = 1'b1;
        model_reset();
        mem_data_ok = 1'b1;
        cyc();
        mem_data_ok = 1'b0;
        sample();
        chk("t7_err_sticky", 71'(err_spurious), 71'd1);
        advance();

        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        inst_acc = 1'b0; data_acc = 1'b0;

        // Random traffic: requesters hold their command until accepted.
        for (int i = 0; i < 3000; i++) begin
            if (!inst_req || inst_acc) begin
                inst_req = ($urandom_range(0, 99) < 55);
                inst_cmd = rnd_cmd();
            end
            if (!data_req || data_acc) begin
                data_req = ($urandom_range(0, 99) < 65);
                data_cmd = rnd_cmd();
            end
            mem_addr_ok = ($urandom_range(0, 99) < 60);
            mem_data_ok = (q_m.size() > 0) ? ($urandom_range(0, 99) < 50)
                                           : ($urandom_range(0, 999) < 3);
            mem_rdata   = $urandom;
            cyc();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
